// File: rtl/line_gen_pkg.sv
// line_gen_pkg
//   Shared types and helpers for the Bresenham line coordinate generator.
//   - state_t  : controller FSM states
//   - abs_diff : |a-b| on unsigned operands up to ABS_W bits; callers
//                zero-extend into it and truncate the result back
//   - max_w    : elaboration-time max, used to size the internal datapath
package line_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int ABS_W = 32;

    function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                   input logic [ABS_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/line_gen_ctrl.sv
// line_gen_ctrl
//   Sequencing FSM for the line generator: IDLE -> SETUP -> EMIT -> DONE.
//   Ports:
//     clk, reset         clock, async active-high reset
//     start              line request (only honoured in IDLE)
//     hs                 point handshake (pt_valid && pt_ready)
//     last               current major coordinate equals the end coordinate
//     err_gtz            error term after adding dy is positive
//     load               latch endpoints this cycle
//     setup              compute swaps / deltas this cycle
//     step               advance the major axis this cycle
//     ystep_en           advance the minor axis this cycle
//     busy, pt_valid, done  status outputs, decoded from state only
module line_gen_ctrl
    import line_gen_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic hs,
    input  logic last,
    input  logic err_gtz,
    output logic load,
    output logic setup,
    output logic step,
    output logic ystep_en,
    output logic busy,
    output logic pt_valid,
    output logic done
);

    state_t state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_SETUP;
            S_SETUP: state_d = S_EMIT;
            S_EMIT:  if (hs && last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs depend on state only, so pt_ready never reaches them
    // combinationally; step/ystep_en are internal datapath enables.
    always_comb begin
        load     = (state_q == S_IDLE) && start;
        setup    = (state_q == S_SETUP);
        step     = (state_q == S_EMIT) && hs && !last;
        ystep_en = step && err_gtz;
        busy     = (state_q != S_IDLE);
        pt_valid = (state_q == S_EMIT);
        done     = (state_q == S_DONE);
    end

endmodule

// File: rtl/line_coordinate_gen.sv
// line_coordinate_gen
//   Eight-octant Bresenham line generator. Endpoints are latched on start,
//   normalised in one SETUP cycle (steep swap, endpoint exchange), then one
//   point per accepted handshake is streamed in increasing major-axis order.
//   Ports:
//     clk, reset        clock, async active-high reset
//     start             line request, sampled in IDLE
//     x0,y0,x1,y1       endpoints (unsigned)
//     busy              line in progress (SETUP/EMIT/DONE)
//     pt_valid/pt_ready point handshake
//     pt_x, pt_y        current point
//     done              one-cycle pulse after the last point is accepted
module line_coordinate_gen
    import line_gen_pkg::*;
#(
    parameter int X_W = 10,
    parameter int Y_W = 9
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    output logic           busy,
    output logic           pt_valid,
    input  logic           pt_ready,
    output logic [X_W-1:0] pt_x,
    output logic [Y_W-1:0] pt_y,
    output logic           done
);

    localparam int W  = max_w(X_W, Y_W);
    localparam int EW = W + 2;

    logic load, setup, step, ystep_en, hs, last, err_gtz;

    // Latched endpoints
    logic [W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [W-1:0] x0_d, y0_d, x1_d, y1_d;

    // Loop state, in the normalised (major = "x") frame
    logic                 steep_q, steep_d;
    logic                 yneg_q, yneg_d;
    logic [W-1:0]         cx_q, cx_d, cy_q, cy_d;
    logic [W-1:0]         xend_q, xend_d;
    logic [W-1:0]         dx_q, dx_d, dy_q, dy_d;
    logic signed [EW-1:0] err_q, err_d;

    // SETUP-cycle normalisation of the latched endpoints
    logic [W-1:0]         adx_c, ady_c;
    logic                 steep_c, swap_c;
    logic [W-1:0]         a0_c, b0_c, a1_c, b1_c;
    logic [W-1:0]         ma0_c, mb0_c, ma1_c, mb1_c;
    logic [W-1:0]         dx_c, dy_c;
    logic signed [EW-1:0] half_c;

    assign adx_c   = W'(abs_diff(ABS_W'(x0_q), ABS_W'(x1_q)));
    assign ady_c   = W'(abs_diff(ABS_W'(y0_q), ABS_W'(y1_q)));
    assign steep_c = ady_c > adx_c;

    assign a0_c = steep_c ? y0_q : x0_q;
    assign b0_c = steep_c ? x0_q : y0_q;
    assign a1_c = steep_c ? y1_q : x1_q;
    assign b1_c = steep_c ? x1_q : y1_q;

    // Walk the major axis upward: exchange endpoints if they run backwards
    assign swap_c = a0_c > a1_c;
    assign ma0_c  = swap_c ? a1_c : a0_c;
    assign mb0_c  = swap_c ? b1_c : b0_c;
    assign ma1_c  = swap_c ? a0_c : a1_c;
    assign mb1_c  = swap_c ? b0_c : b1_c;

    assign dx_c   = ma1_c - ma0_c;
    assign dy_c   = W'(abs_diff(ABS_W'(mb0_c), ABS_W'(mb1_c)));
    assign half_c = $signed({2'b00, dx_c}) >>> 1;

    // EMIT-cycle error update
    logic signed [EW-1:0] err_add;
    assign err_add = err_q + $signed({2'b00, dy_q});
    assign err_gtz = !err_add[EW-1] && (err_add != '0);

    assign last = (cx_q == xend_q);
    assign hs   = pt_valid && pt_ready;

    always_comb begin
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        steep_d = steep_q;
        yneg_d  = yneg_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        xend_d  = xend_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        if (load) begin
            x0_d = W'(x0);
            y0_d = W'(y0);
            x1_d = W'(x1);
            y1_d = W'(y1);
        end
        if (setup) begin
            steep_d = steep_c;
            yneg_d  = !(mb0_c < mb1_c);
            cx_d    = ma0_c;
            cy_d    = mb0_c;
            xend_d  = ma1_c;
            dx_d    = dx_c;
            dy_d    = dy_c;
            err_d   = -half_c;
        end
        if (step) begin
            cx_d  = cx_q + W'(1);
            err_d = err_add;
            if (ystep_en) begin
                cy_d  = yneg_q ? (cy_q - W'(1)) : (cy_q + W'(1));
                err_d = err_add - $signed({2'b00, dx_q});
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            steep_q <= 1'b0;
            yneg_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            xend_q  <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
        end else begin
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            steep_q <= steep_d;
            yneg_q  <= yneg_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            xend_q  <= xend_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
        end
    end

    // Undo the steep swap on the way out; both loop registers reset to 0
    always_comb begin
        pt_x = steep_q ? cy_q[X_W-1:0] : cx_q[X_W-1:0];
        pt_y = steep_q ? cx_q[Y_W-1:0] : cy_q[Y_W-1:0];
    end

    line_gen_ctrl u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .hs       (hs),
        .last     (last),
        .err_gtz  (err_gtz),
        .load     (load),
        .setup    (setup),
        .step     (step),
        .ystep_en (ystep_en),
        .busy     (busy),
        .pt_valid (pt_valid),
        .done     (done)
    );

endmodule

// File: doc/line_coordinate_gen.md
# line_coordinate_gen

Parametrised Bresenham line coordinate generator covering all eight octants. It latches two endpoints on `start` and streams every pixel coordinate of the line over a ready/valid interface, one point per cycle when unstalled. It sits between the line-request logic and the VGA framebuffer writer. It supersedes the single-octant, fixed-width controller/datapath pair: it adds endpoint reordering, negative y-step, backpressure and completion signalling.

## Interface
- `X_W`, default 10: x coordinate width (640-wide screen)
- `Y_W`, default 9: y coordinate width (480-high screen)
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; forces IDLE
- `start`  in  1  request; sampled only in IDLE
- `x0`, `x1`  in  X_W  endpoint x, unsigned
- `y0`, `y1`  in  Y_W  endpoint y, unsigned
- `busy`  out  1  high in SETUP, EMIT, DONE
- `pt_valid`  out  1  `pt_x`/`pt_y` hold a point
- `pt_ready`  in  1  consumer accepts point
- `pt_x`  out  X_W  point x
- `pt_y`  out  Y_W  point y
- `done`  out  1  one-cycle pulse after last point accepted

## Operation
- Internal coordinate width is W = max(X_W, Y_W). The error register is signed, W+2 bits.
- IDLE:
  - `start`=1 registers the endpoints and goes to SETUP.
  - `start`=0 stays in IDLE.
- SETUP (1 cycle):
  - steep = |y1−y0| > |x1−x0|. If steep, swap x and y of both endpoints.
  - If the swapped x0 > x1, exchange the endpoints.
  - dx = x1−x0 and dy = |y1−y0|. err = −(dx>>1), arithmetic.
  - ystep = +1 if y0<y1, else −1. Loop x = x0, y = y0. Go to EMIT.
- EMIT:
  - `pt_valid`=1. Output (`pt_x`,`pt_y`) = steep ? (y,x) : (x,y), truncated to X_W/Y_W.
  - On handshake (`pt_valid && pt_ready`) with x == x1, go to DONE.
  - On any other handshake: x += 1 and err += dy; if the updated err > 0, then y += ystep and err −= dx.
  - With no handshake, all state holds.
- DONE (1 cycle): `done`=1, then IDLE.
- Point count is max(|dx|,|dy|)+1. Points are emitted in increasing major-axis order, which is not necessarily from (x0,y0).
- Degenerate line (x0==x1, y0==y1): exactly one point.
- `start` in any state other than IDLE is ignored. Endpoint inputs are don't-care outside IDLE.
- Reset mid-line: state returns to IDLE immediately. No `done` is pulsed and the partial line is abandoned.

## Timing
- Reset values: `busy`=0, `pt_valid`=0, `done`=0, `pt_x`=0, `pt_y`=0. The FSM is in IDLE.
- All outputs are registered or decoded from the state register. There is no combinational path from `pt_ready` to any output.
- Cycle t: `start` sampled. Cycle t+1: SETUP, `busy`=1. Cycle t+2: first `pt_valid`.
- Throughput is one point per cycle while `pt_ready`=1.
- `pt_x`/`pt_y` are stable while `pt_valid`=1 and `pt_ready`=0.
- `done` is asserted the cycle after the last handshake. `busy` falls the cycle after `done`, and a new `start` is accepted then.
- Minimum line latency, start to done, is N+2 cycles for N points with no stalls.

## Structure
- Package `line_gen_pkg`:
  - state enum {S_IDLE, S_SETUP, S_EMIT, S_DONE}
  - function `abs_diff` (parametrised by width)
  - localparam helper for W = max(X_W,Y_W)
- Sub-module `line_gen_ctrl`:
  - Contains the FSM.
  - Inputs: `start`, handshake, `last` (x==x1), `err_gtz`.
  - Outputs: `load`, `setup`, `step`, `ystep_en`, `busy`, `pt_valid`, `done`.
- Datapath (registers, swaps, error arithmetic) lives in the top module.

## Test plan
- Horizontal (0,0)→(3,0), ready=1 → points (0,0),(1,0),(2,0),(3,0) on consecutive cycles starting t+2; `done` pulses at t+6.
- Shallow (0,0)→(4,2) → (0,0),(1,0),(2,1),(3,1),(4,2).
- Steep reversed (2,5)→(0,0) → (0,0),(0,1),(1,2),(1,3),(2,4),(2,5). This exercises the steep swap and the endpoint exchange.
- Backpressure on (0,0)→(4,2) with `pt_ready` low for 3 cycles after the 2nd point:
  - (1,0) is held stable for those 3 cycles.
  - Exactly 5 points are emitted, with no duplicates.
  - `done` pulses once.
- Degenerate (7,7)→(7,7) → one point (7,7), then `done`. Also: `start` pulsed during EMIT is ignored. Also: negative ystep (0,3)→(3,0) gives (0,3),(1,2),(2,1),(3,0).
- Reset asserted mid-EMIT, asynchronously between clock edges → `pt_valid`, `busy` and `done` drop to 0 before the next edge. The next `start` (1023,479)→(0,479) with default widths produces 1024 points ending at (1023,479).
